// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array front end: default geometry,
// feeder state encoding and the drain length used by feeder and sa_2D output.
package sa_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_N     = 64;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_FLUSH  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   // Zero cycles needed after the last beat until the last product leaves the array.
   function automatic int flush_len(input int n);
      return 2 * n - 1;
   endfunction

endpackage

// File: rtl/sa_lane_delay.sv
// Fixed-depth shift chain for one skew lane; latency DEPTH cycles, never stalls,
// no backpressure (advances every cycle), synchronous active-high clear.
module sa_lane_delay #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
      end else begin
         stage[0] <= d;
         for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// Skews unskewed A/B lane vectors into the sa_2D wavefront; lane i latency i+1 cycles.
// Accepts beats in IDLE/STREAM only; in_ready drops for the zero flush and done cycle.
module sa_skew_feeder
   import sa_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int N         = DEF_N,
   parameter int FLUSH_LEN = flush_len(N)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_last,
   input  logic [WIDTH*N-1:0] A_IN,
   input  logic [WIDTH*N-1:0] B_IN,
   output logic [WIDTH*N-1:0] AA,
   output logic [WIDTH*N-1:0] BB,
   output logic               busy,
   output logic               done
);

   localparam int CW = $clog2(FLUSH_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FLUSH_LEN - 1);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] flush_cnt;
   logic          accept;

   assign accept = in_valid && in_ready;

   always_ff @(posedge CLK) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept) state_nxt = in_last ? S_FLUSH : S_STREAM;
         S_STREAM: if (accept && in_last) state_nxt = S_FLUSH;
         S_FLUSH:  if (flush_cnt == CNT_LAST) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Reset forces all handshake/status outputs low for the whole reset cycle.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      if (!RST) begin
         case (state)
            S_IDLE:   in_ready = 1'b1;
            S_STREAM: begin
               in_ready = 1'b1;
               busy     = 1'b1;
            end
            S_FLUSH:  busy = 1'b1;
            S_DONE:   done = 1'b1;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST)
         flush_cnt <= '0;
      else if (state == S_FLUSH && flush_cnt != CNT_LAST)
         flush_cnt <= flush_cnt + CW'(1);
      else
         flush_cnt <= '0;
   end

   // Chain heads load zero whenever nothing is accepted: bubbles and flush alike.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [WIDTH-1:0] head_a;
      logic [WIDTH-1:0] head_b;

      assign head_a = accept ? A_IN[i*WIDTH +: WIDTH] : '0;
      assign head_b = accept ? B_IN[i*WIDTH +: WIDTH] : '0;

      sa_lane_delay #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_dly_a (
         .clk (CLK),
         .rst (RST),
         .d   (head_a),
         .q   (AA[i*WIDTH +: WIDTH])
      );

      sa_lane_delay #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_dly_b (
         .clk (CLK),
         .rst (RST),
         .d   (head_b),
         .q   (BB[i*WIDTH +: WIDTH])
      );
   end

endmodule
